// File: rtl/spi_master_ctrl.sv
// SPI master: one 16-bit {addr, rw, data} frame per start, MSB first, sclk idles low.
// Optional define SPI_MISO_SYNC_EN puts a 2-flop synchronizer on miso_pin.
//
// state | meaning
// IDLE  | cs high, waiting for start
// SETUP | cs low, sclk low for CLKDIV cycles before the first bit
// SHIFT | 16 bits, each CLKDIV low then CLKDIV high
// HOLD  | cs low, sclk low for CLKDIV cycles, then done
module spi_master_ctrl #(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKDIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [15:0]   sr, sr_n;
  logic          rw_q, rw_n;
  logic          sclk_n, cs_n, mosi_n, busy_n, done_n;
  logic [7:0]    rdata_n;
  logic [15:0]   frame;
  logic          miso_s;
  logic          tc;

`ifdef SPI_MISO_SYNC_EN
  logic miso_m1, miso_m2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_m1 <= 1'b0;
      miso_m2 <= 1'b0;
    end else begin
      miso_m1 <= miso_pin;
      miso_m2 <= miso_m1;
    end
  end
  assign miso_s = miso_m2;
`else
  assign miso_s = miso_pin;
`endif

  assign frame = {addr, rw, (rw ? 8'h00 : wdata)};
  assign tc    = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      rw_q     <= 1'b0;
      sclk_pin <= 1'b0;
      cs_pin   <= 1'b1;
      mosi_pin <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      sr       <= sr_n;
      rw_q     <= rw_n;
      sclk_pin <= sclk_n;
      cs_pin   <= cs_n;
      mosi_pin <= mosi_n;
      busy     <= busy_n;
      done     <= done_n;
      rdata    <= rdata_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    sr_n    = sr;
    rw_n    = rw_q;
    sclk_n  = sclk_pin;
    cs_n    = cs_pin;
    mosi_n  = mosi_pin;
    busy_n  = busy;
    done_n  = 1'b0;
    rdata_n = rdata;

    case (state)
      IDLE: begin
        if (start) begin
          sr_n    = {frame[14:0], 1'b0};
          mosi_n  = frame[15];
          rw_n    = rw;
          cs_n    = 1'b0;
          busy_n  = 1'b1;
          sclk_n  = 1'b0;
          cnt_n   = CNT_LOAD;
          bit_n   = '0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (tc) begin
          cnt_n   = CNT_LOAD;
          state_n = SHIFT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      SHIFT: begin
        if (!tc) begin
          cnt_n = cnt - 1'b1;
        end else begin
          cnt_n = CNT_LOAD;
          if (!sclk_pin) begin
            sclk_n = 1'b1;
          end else begin
            // Last clk of the high phase: sample miso, then drop sclk and advance mosi
            sclk_n = 1'b0;
            mosi_n = sr[15];
            sr_n   = {sr[14:0], 1'b0};
            if (rw_q && bit_cnt[3])
              rdata_n = {rdata[6:0], miso_s};
            bit_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15)
              state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (tc) begin
          cs_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
